// File: rtl/cbus_arbiter_pkg.sv
// Shared types for the cbus two-into-one arbiter: bus request/response structs,
// arbiter state encoding and beat-counter width.
package cbus_arbiter_pkg;

    localparam int ARB_BEAT_W   = 4;
    localparam int CBUS_ADDR_W  = 32;
    localparam int CBUS_DATA_W  = 32;
    localparam int CBUS_STRB_W  = CBUS_DATA_W / 8;
    localparam int ARB_STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [3:0]             len;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_STRB_W-1:0] strb;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    // Forward a granted request with valid forced high, whatever the owner drives.
    function automatic cbus_req_t cbus_req_granted(input cbus_req_t req);
        cbus_req_t r;
        r       = req;
        r.valid = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of the arbiter's bus-side signals. The slave modport is the arbiter's
// view; the master modport is the view of the core/bridge side driving it.
interface cbus_arbiter_if;
    import cbus_arbiter_pkg::*;

    cbus_req_t              ireq;
    cbus_resp_t             iresp;
    cbus_req_t              dreq;
    cbus_resp_t             dresp;
    cbus_req_t              oreq;
    cbus_resp_t             oresp;
    logic                   busy;
    logic                   grant_d;
    logic [ARB_BEAT_W-1:0]  beat_cnt;

    modport slave (
        input  ireq, dreq, oresp,
        output iresp, dresp, oreq, busy, grant_d, beat_cnt
    );

    modport master (
        output ireq, dreq, oresp,
        input  iresp, dresp, oreq, busy, grant_d, beat_cnt
    );

endinterface

// File: rtl/cbus_arbiter_pick.sv
// Combinational arbitration policy for cbus_arbiter: picks the winner among the
// valid requesters. Round-robin replaces fixed priority when CBUS_ARB_RR_EN is defined.
module cbus_arb_pick
    import cbus_arbiter_pkg::*;
#(
    parameter int D_PRIORITY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_ivalid,
    input  logic                    i_dvalid,
`ifdef CBUS_ARB_RR_EN
    input  logic                    i_last_owner,
`else
    input  logic [ARB_STARVE_W-1:0] i_starve_cnt,
`endif
    output logic                    o_pick_d
);

`ifdef CBUS_ARB_RR_EN
    always_comb begin
        if (i_ivalid && i_dvalid) begin
            o_pick_d = ~i_last_owner;
        end else begin
            o_pick_d = i_dvalid;
        end
    end
`else
    localparam logic                    PRIO_D = (D_PRIORITY != 0);
    localparam logic [ARB_STARVE_W-1:0] LIMIT  = ARB_STARVE_W'(STARVE_LIMIT);

    // A starved non-priority side takes exactly one arbitration, then priority resumes.
    always_comb begin
        if (i_ivalid && i_dvalid) begin
            o_pick_d = (i_starve_cnt == LIMIT) ? ~PRIO_D : PRIO_D;
        end else begin
            o_pick_d = i_dvalid;
        end
    end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Two-into-one cbus arbiter: instruction and data cache buses share one memory port,
// grant locked per transaction. Optional macro CBUS_ARB_RR_EN selects round-robin.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int D_PRIORITY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    cbus_arbiter_if.slave bus
);

    // state  | meaning
    // IDLE   | no owner, arbitrate on any valid request
    // BUSY_I | instruction side owns the memory port until last beat
    // BUSY_D | data side owns the memory port until last beat
    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_BUSY_I = 2'(BUSY_I);
    localparam logic [1:0] S_BUSY_D = 2'(BUSY_D);

    logic [1:0]            r_state;
    logic [ARB_BEAT_W-1:0] r_beat;
    logic                  w_any_req;
    logic                  w_both_req;
    logic                  w_grant;
    logic                  w_release;
    logic                  w_pick_d;

    assign w_any_req  = bus.ireq.valid | bus.dreq.valid;
    assign w_both_req = bus.ireq.valid & bus.dreq.valid;
    assign w_grant    = (r_state == S_IDLE) && w_any_req;
    assign w_release  = (r_state != S_IDLE) && bus.oresp.ready && bus.oresp.last;

`ifdef CBUS_ARB_RR_EN
    logic r_last_owner;

    cbus_arb_pick #(
        .D_PRIORITY   (D_PRIORITY),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_ivalid     (bus.ireq.valid),
        .i_dvalid     (bus.dreq.valid),
        .i_last_owner (r_last_owner),
        .o_pick_d     (w_pick_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_owner <= 1'b0;
        end else if (w_grant) begin
            r_last_owner <= w_pick_d;
        end
    end
`else
    localparam logic                    PRIO_D = (D_PRIORITY != 0);
    localparam logic [ARB_STARVE_W-1:0] LIMIT  = ARB_STARVE_W'(STARVE_LIMIT);

    logic [ARB_STARVE_W-1:0] r_starve_cnt;

    cbus_arb_pick #(
        .D_PRIORITY   (D_PRIORITY),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_ivalid     (bus.ireq.valid),
        .i_dvalid     (bus.dreq.valid),
        .i_starve_cnt (r_starve_cnt),
        .o_pick_d     (w_pick_d)
    );

    // Only contested wins by the priority side count; a lone priority request leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (w_pick_d != PRIO_D) begin
                r_starve_cnt <= '0;
            end else if (w_both_req && (r_starve_cnt != LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= w_pick_d ? S_BUSY_D : S_BUSY_I;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (w_release) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat <= '0;
        end else if (r_state == S_IDLE) begin
            r_beat <= '0;
        end else if (bus.oresp.ready) begin
            r_beat <= w_release ? '0 : r_beat + 1'b1;
        end
    end

    // Routing depends only on registered state, so requests never reach oreq.valid combinationally.
    always_comb begin
        bus.oreq  = '0;
        bus.iresp = '0;
        bus.dresp = '0;
        case (r_state)
            S_BUSY_I: begin
                bus.oreq  = cbus_req_granted(bus.ireq);
                bus.iresp = bus.oresp;
            end
            S_BUSY_D: begin
                bus.oreq  = cbus_req_granted(bus.dreq);
                bus.dresp = bus.oresp;
            end
            default: ;
        endcase
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.grant_d  = (r_state == S_BUSY_D);
    assign bus.beat_cnt = r_beat;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed arbitration scenarios plus randomized
// transactions checked against a transaction-level model of the grant policy.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int D_PRIO = 1;
    localparam int LIMIT  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cbus_arbiter_if bus();

    cbus_arbiter #(
        .D_PRIORITY   (D_PRIO),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Policy model: who wins an arbitration, and what the fairness state becomes.
    int m_starve  = 0;
    bit m_last_d  = 1'b0;

    function automatic bit model_pick(input bit iv, input bit dv);
        if (!(iv && dv)) return dv;
`ifdef CBUS_ARB_RR_EN
        return !m_last_d;
`else
        if (m_starve == LIMIT) return (D_PRIO == 0);
        return (D_PRIO != 0);
`endif
    endfunction

    function automatic void model_grant(input bit iv, input bit dv, input bit win_d);
`ifdef CBUS_ARB_RR_EN
        m_last_d = win_d;
`else
        if (win_d != (D_PRIO != 0)) m_starve = 0;
        else if (iv && dv && m_starve < LIMIT) m_starve++;
`endif
    endfunction

    function automatic cbus_req_t rand_req(input bit v, input int len);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = 1'($urandom_range(0, 1));
        r.addr     = $urandom;
        r.len      = 4'(len);
        r.data     = $urandom;
        r.strb     = 4'($urandom);
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},     bus.busy, 1'b0);
        check_eq({tag, "_oreq_vld"}, bus.oreq.valid, 1'b0);
        check_eq({tag, "_iresp"},    bus.iresp, '0);
        check_eq({tag, "_dresp"},    bus.dresp, '0);
    endtask

    // One arbitration plus the full transaction of the winner. Entered and left at a
    // falling edge with the DUT idle; got_d is the observed grant.
    task automatic do_round(input bit iv, input bit dv, input int len_i, input int len_d,
                            input int max_gap, output bit got_d);
        cbus_req_t  exp_o;
        bit         win_d;
        bit         rdy;
        int         beats;
        int         beat;
        bus.ireq        = rand_req(iv, len_i);
        bus.dreq        = rand_req(dv, len_d);
        bus.oresp.ready = 1'($urandom_range(0, 1));
        bus.oresp.last  = 1'($urandom_range(0, 1));
        bus.oresp.data  = $urandom;
        #1;
        check_idle_outputs("arb");
        win_d = model_pick(iv, dv);
        model_grant(iv, dv, win_d);
        beats = (win_d ? len_d : len_i) + 1;
        beat  = 0;
        got_d = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int cyc = 0; cyc < 64 && beat < beats; cyc++) begin
            if (win_d) begin
                bus.dreq.data = $urandom;
                bus.dreq.strb = 4'($urandom);
                if ($urandom_range(0, 15) == 0) bus.dreq.valid = 1'b0;
            end else begin
                bus.ireq.data = $urandom;
                bus.ireq.strb = 4'($urandom);
                if ($urandom_range(0, 15) == 0) bus.ireq.valid = 1'b0;
            end
            rdy             = (cyc >= 40) || ($urandom_range(0, max_gap) == 0);
            bus.oresp.ready = rdy;
            bus.oresp.last  = rdy ? (beat == beats - 1) : 1'($urandom_range(0, 1));
            bus.oresp.data  = $urandom;
            #1;
            if (cyc == 0) got_d = bus.grant_d;
            check_eq("busy",     bus.busy, 1'b1);
            check_eq("grant_d",  bus.grant_d, win_d);
            check_eq("beat_cnt", bus.beat_cnt, beat);
            exp_o       = win_d ? bus.dreq : bus.ireq;
            exp_o.valid = 1'b1;
            check_eq("oreq", bus.oreq, exp_o);
            check_eq("owner_resp", win_d ? bus.dresp : bus.iresp, bus.oresp);
            check_eq("other_resp", win_d ? bus.iresp : bus.dresp, '0);
            if (rdy) beat++;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("beats_done", beat, beats);
        bus.oresp = '0;
    endtask

    task automatic idle_noise();
        bus.ireq        = rand_req(1'b0, 0);
        bus.dreq        = rand_req(1'b0, 0);
        bus.oresp.ready = 1'b1;
        bus.oresp.last  = 1'($urandom_range(0, 1));
        bus.oresp.data  = $urandom;
        #1;
        check_idle_outputs("noise");
        @(posedge clk);
        @(negedge clk);
        check_eq("noise_stays_idle", bus.busy, 1'b0);
        bus.oresp = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        bit         gd;
        bit         pend_i;
        bit         pend_d;
        logic [5:0] exp_seq;
        bus.ireq  = '0;
        bus.dreq  = '0;
        bus.oresp = '0;
        #3;
        check_idle_outputs("reset");
        check_eq("reset_grant_d", bus.grant_d, 1'b0);
        check_eq("reset_beat",    bus.beat_cnt, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Simultaneous requests: data side first, then the waiting instruction side.
        do_round(1'b1, 1'b1, 1, 2, 1, gd);
        check_eq("simul_first_d", gd, 1'b1);
        do_round(1'b1, 1'b0, 2, 0, 1, gd);
        check_eq("simul_then_i", gd, 1'b0);

        // Both sides held valid across back-to-back transactions.
`ifdef CBUS_ARB_RR_EN
        exp_seq = 6'b010101;
`else
        exp_seq = 6'b101111;
`endif
        for (int k = 0; k < 6; k++) begin
            do_round(1'b1, 1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 1, gd);
            check_eq($sformatf("contend_%0d", k), gd, exp_seq[k]);
`ifndef CBUS_ARB_RR_EN
            if (k == 4) check_eq("starve_cleared", dut.r_starve_cnt, '0);
`endif
        end

        // Single data read with wait states, then a 4-beat instruction burst.
        do_round(1'b0, 1'b1, 0, 0, 3, gd);
        check_eq("single_read_d", gd, 1'b1);
        do_round(1'b1, 1'b0, 3, 0, 1, gd);
        check_eq("burst_i", gd, 1'b0);

        idle_noise();

        pend_i = 1'b0;
        pend_d = 1'b0;
        for (int r = 0; r < 40; r++) begin
            bit iv;
            bit dv;
            int pat;
            pat = $urandom_range(1, 3);
            iv  = pend_i | pat[0];
            dv  = pend_d | pat[1];
            do_round(iv, dv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), gd);
            pend_i = iv && gd;
            pend_d = dv && !gd;
            if ($urandom_range(0, 4) == 0) begin
                idle_noise();
                pend_i = 1'b0;
                pend_d = 1'b0;
            end
        end

        // Reset asserted during beat 2 of a data burst.
        bus.ireq  = rand_req(1'b0, 0);
        bus.dreq  = rand_req(1'b1, 3);
        bus.oresp = '0;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.oresp.ready = 1'b1;
            bus.oresp.last  = 1'b0;
            bus.oresp.data  = $urandom;
        end
        @(negedge clk);
        bus.oresp.ready = 1'b1;
        bus.oresp.data  = $urandom;
        #1;
        check_eq("pre_rst_busy",     bus.busy, 1'b1);
        check_eq("pre_rst_beat",     bus.beat_cnt, 2);
        check_eq("pre_rst_dresp",    bus.dresp, bus.oresp);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_oreq_vld", bus.oreq.valid, 1'b0);
        check_eq("rst_dresp",    bus.dresp, '0);
        check_eq("rst_busy",     bus.busy, 1'b0);
        m_starve = 0;
        m_last_d = 1'b0;
        @(negedge clk);
        bus.dreq.valid = 1'b0;
        bus.oresp      = '0;
        reset          = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("post_rst");

        do_round(1'b1, 1'b1, 1, 1, 1, gd);
        check_eq("post_rst_first_d", gd, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
